lampfpu_sqrt_arb: RTL and testbench

- Shares one iterative bfloat16 square-root unit (1-bit sign, 8-bit exponent, 7-bit fraction) between N_REQ requesters.
- Round-robin arbitration; accepted operand decoded into the unit's field/class inputs and held stable for the whole operation.
- Watches the unit's valid with a watchdog; returns the result tagged with requester ID over a valid/ready response channel.
- Sits between the FPU issue logic and the sqrt datapath; exactly one operation in flight.

---
 rtl/lampfpu_sqrt_arb.sv | 235 +++++++++++++++++++++++
 tb/tb_lampfpu_sqrt_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lampfpu_sqrt_arb.sv
// ============================================================================
// Module      : lampfpu_sqrt_arb
// Description : Shares one iterative bfloat16 square-root unit between
//               N_REQ requesters. A round-robin arbiter accepts one operand.
//               The operand is decoded into the unit's field/class inputs and
//               held there. A watchdog guards the unit's result valid, and the
//               result is returned with the requester ID on a valid/ready
//               response channel. Exactly one operation is in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i [N_REQ]       per-requester request valid
//   req_op_i   [16*N_REQ]     packed bfloat16 operands, requester k at [16k+:16]
//   req_ready_o [N_REQ]       one-hot accept (IDLE only)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_id_o, rsp_res_o       requester index and {s,e,f} result
//   rsp_err_o                 watchdog expired, result is QNaN
//   busy_o                    an operation is in progress
//   sqrt_do_o                 one-cycle start pulse to the unit
//   sqrt_sign_o/exp_o/mant_o  decoded operand fields (held until next capture)
//   sqrt_is*_o                operand class flags (held until next capture)
//   sqrt_s_i/e_i/f_i/valid_i  unit result and single-cycle valid
// ============================================================================
`default_nettype none

module lampfpu_sqrt_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [16*N_REQ-1:0]  req_op_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [15:0]          rsp_res_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 sqrt_do_o,
    output logic                 sqrt_sign_o,
    output logic [7:0]           sqrt_exp_o,
    output logic [7:0]           sqrt_mant_o,
    output logic                 sqrt_isInf_o,
    output logic                 sqrt_isZero_o,
    output logic                 sqrt_isSNAN_o,
    output logic                 sqrt_isQNAN_o,
    input  logic                 sqrt_s_i,
    input  logic [7:0]           sqrt_e_i,
    input  logic [6:0]           sqrt_f_i,
    input  logic                 sqrt_valid_i
);

    localparam int               CNT_W      = $clog2(TIMEOUT);
    // The timeout decision is taken in the WAIT cycle where the counter is
    // about to step to TIMEOUT-1, so the error response appears TIMEOUT
    // cycles after the start pulse.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [15:0]      C_QNAN     = 16'h7FC0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  rr_d;
    logic [CNT_W-1:0] cnt_q;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [15:0]      rsp_res_q;
    logic             rsp_err_q;
    logic             busy_q;
    logic             do_q;

    logic             sign_q;
    logic [7:0]       exp_q;
    logic [7:0]       mant_q;
    logic             inf_q;
    logic             zero_q;
    logic             snan_q;
    logic             qnan_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_q, wrapping.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [ID_W-1:0]  cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(rr_q) + i) % N_REQ);
            if (!gnt_vld && req_valid_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign rr_d = ID_W'((int'(gnt_idx) + 1) % N_REQ);

    // Operand of the granted requester.
    logic [15:0] op_sel;

    always_comb begin
        op_sel = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (gnt_idx == ID_W'(j)) begin
                op_sel = req_op_i[16*j +: 16];
            end
        end
    end

    // Field/class decode of the selected operand.
    logic [7:0] dec_exp;
    logic [6:0] dec_frac;
    logic       dec_exp_max;
    logic       dec_exp_zero;

    assign dec_exp      = op_sel[14:7];
    assign dec_frac     = op_sel[6:0];
    assign dec_exp_max  = &dec_exp;
    assign dec_exp_zero = ~|dec_exp;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            do_q        <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            snan_q      <= 1'b0;
            qnan_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        rsp_id_q <= gnt_idx;
                        rr_q     <= rr_d;
                        sign_q   <= op_sel[15];
                        exp_q    <= dec_exp;
                        // Subnormals are flushed to zero, so the mantissa
                        // is cleared too rather than exposing the fraction.
                        mant_q   <= dec_exp_zero ? 8'h00 : {1'b1, dec_frac};
                        zero_q   <= dec_exp_zero;
                        inf_q    <= dec_exp_max && (dec_frac == 7'd0);
                        qnan_q   <= dec_exp_max && dec_frac[6];
                        snan_q   <= dec_exp_max && (dec_frac != 7'd0) && !dec_frac[6];
                        busy_q   <= 1'b1;
                        do_q     <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    do_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A result arriving on the timeout cycle still wins.
                    if (sqrt_valid_i) begin
                        rsp_res_q   <= {sqrt_s_i, sqrt_e_i, sqrt_f_i};
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == C_CNT_LAST) begin
                        rsp_res_q   <= C_QNAN;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Grants are only offered from IDLE and never while reset is applied.
    assign req_ready_o   = (state_q == S_IDLE && !rst) ? gnt_oh : '0;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_res_o     = rsp_res_q;
    assign rsp_err_o     = rsp_err_q;
    assign busy_o        = busy_q;
    assign sqrt_do_o     = do_q;
    assign sqrt_sign_o   = sign_q;
    assign sqrt_exp_o    = exp_q;
    assign sqrt_mant_o   = mant_q;
    assign sqrt_isInf_o  = inf_q;
    assign sqrt_isZero_o = zero_q;
    assign sqrt_isSNAN_o = snan_q;
    assign sqrt_isQNAN_o = qnan_q;

endmodule

`default_nettype wire

// File: tb/tb_lampfpu_sqrt_arb.sv
// ============================================================================
// Module      : tb_lampfpu_sqrt_arb
// Description : Self-checking bench for lampfpu_sqrt_arb. Acts as the
//               requesters, the sqrt unit (programmable latency, or silent)
//               and the response sink; compares against a transaction-level
//               model of arbitration order, operand classification and
//               response timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lampfpu_sqrt_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [16*N-1:0]   req_op;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_res;
    logic              rsp_err;
    logic              busy;
    logic              sq_do;
    logic              sq_sign;
    logic [7:0]        sq_exp;
    logic [7:0]        sq_mant;
    logic              sq_inf, sq_zero, sq_snan, sq_qnan;
    logic              u_s;
    logic [7:0]        u_e;
    logic [6:0]        u_f;
    logic              u_valid;

    lampfpu_sqrt_arb #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_op_i      (req_op),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_res_o     (rsp_res),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy),
        .sqrt_do_o     (sq_do),
        .sqrt_sign_o   (sq_sign),
        .sqrt_exp_o    (sq_exp),
        .sqrt_mant_o   (sq_mant),
        .sqrt_isInf_o  (sq_inf),
        .sqrt_isZero_o (sq_zero),
        .sqrt_isSNAN_o (sq_snan),
        .sqrt_isQNAN_o (sq_qnan),
        .sqrt_s_i      (u_s),
        .sqrt_e_i      (u_e),
        .sqrt_f_i      (u_f),
        .sqrt_valid_i  (u_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rr_m  = 0;   // model round-robin pointer

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: first requester with a valid at or after the pointer, wrapping.
    function automatic int model_grant(input logic [N-1:0] vm);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (rr_m + i) % N;
            if (vm[k]) return k;
        end
        return -1;
    endfunction

    // Model: {sign, exp, mant, inf, zero, snan, qnan} from IEEE-style rules.
    function automatic logic [20:0] model_dec(input logic [15:0] op);
        int e, f;
        logic zero, inf, qnan, snan;
        logic [7:0] mant;
        e    = int'(op[14:7]);
        f    = int'(op[6:0]);
        zero = (e == 0);
        inf  = (e == 255) && (f == 0);
        qnan = (e == 255) && (f >= 64);
        snan = (e == 255) && (f > 0) && (f < 64);
        mant = zero ? 8'd0 : 8'(128 + f);
        return {op[15], op[14:7], mant, inf, zero, snan, qnan};
    endfunction

    function automatic logic [20:0] obs_dec();
        return {sq_sign, sq_exp, sq_mant, sq_inf, sq_zero, sq_snan, sq_qnan};
    endfunction

    function automatic logic [63:0] obs_all();
        return 64'({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy, sq_do, obs_dec()});
    endfunction

    // One full transaction. lat = cycles after the start pulse at which the
    // unit returns (outside 1..TO-1 means the unit stays silent).
    task automatic do_op(input logic [N-1:0] vm, input logic [16*N-1:0] ops,
                         input int lat, input logic [15:0] ures, input int bp,
                         output int g);
        logic [20:0] edec;
        logic [15:0] eres;
        logic        eerr;
        int          expk;
        logic [63:0] snap;
        req_valid = vm;
        req_op    = ops;
        #1;
        g = model_grant(vm);
        check_val("grant", 64'(req_ready), 64'(1) << g);
        edec = model_dec(ops[16*g +: 16]);
        tick();                       // handshake edge, now in ISSUE
        rr_m = (g + 1) % N;
        check_val("start_pulse", {62'd0, sq_do, busy}, 64'd3);
        check_val("ready_busy", 64'(req_ready), 64'd0);
        check_val("decode", 64'(obs_dec()), 64'(edec));
        if (lat >= 1 && lat <= TO - 1) begin
            expk = lat + 1;
            eres = ures;
            eerr = 1'b0;
        end else begin
            expk = TO;
            eres = 16'h7FC0;
            eerr = 1'b1;
        end
        for (int k = 1; k <= expk; k++) begin
            u_valid = (k - 1 == lat);
            {u_s, u_e, u_f} = ures;
            tick();
            if (k == 1) check_val("pulse_width", 64'(sq_do), 64'd0);
            if (k == expk - 1) begin
                check_val("early_rsp", 64'(rsp_valid), 64'd0);
                check_val("decode_held", 64'(obs_dec()), 64'(edec));
            end
        end
        u_valid = 1'b0;
        check_val("rsp", 64'({rsp_valid, rsp_id, rsp_res, rsp_err}),
                  64'({1'b1, IDW'(g), eres, eerr}));
        snap = 64'({rsp_valid, rsp_id, rsp_res, rsp_err, req_ready});
        for (int b = 0; b < bp; b++) begin
            tick();
            check_val("rsp_hold", 64'({rsp_valid, rsp_id, rsp_res, rsp_err, req_ready}), snap);
        end
        rsp_ready = 1'b1;
        tick();                       // accept edge
        rsp_ready = 1'b0;
        check_val("after_accept", 64'({rsp_valid, busy}), 64'd0);
        if (vm != '0)
            check_val("regrant", 64'(req_ready), 64'(1) << model_grant(vm));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        u_valid   = 1'b0;
        tick();
        tick();
        check_val("reset_outputs", obs_all(), 64'd0);
        rst  = 1'b0;
        rr_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        logic [16*N-1:0] ops;
        logic [15:0] op1;
        logic [15:0] specials [4];

        rst = 1'b1; req_valid = '0; req_op = '0; rsp_ready = 1'b0;
        u_valid = 1'b0; u_s = 1'b0; u_e = '0; u_f = '0;
        do_reset();

        // Round-robin with everyone requesting continuously.
        for (int i = 0; i < 5; i++) begin
            ops = {$urandom, $urandom};
            do_op(4'hF, ops, int'($urandom_range(1, 10)), 16'($urandom), 0, g);
            check_val("rr_order", 64'(g), 64'(i % N));
        end

        // Single request: 4.0 from requester 2, unit answers 2.0 after 5.
        ops = '0;
        ops[47:32] = 16'h4080;
        do_op(4'b0100, ops, 5, 16'h4000, 0, g);

        // Backpressure for 10 cycles with other requests pending.
        ops = {$urandom, $urandom};
        do_op(4'b1011, ops, 3, 16'h3F80, 10, g);

        // Silent unit -> watchdog; then valid on the timeout cycle.
        do_op(4'b0001, {$urandom, $urandom}, -1, 16'h1234, 0, g);
        do_op(4'b0010, {$urandom, $urandom}, TO - 1, 16'h4321, 0, g);
        do_op(4'b0100, {$urandom, $urandom}, TO - 2, 16'h2468, 1, g);

        // Operand class decode.
        specials[0] = 16'h7F80; specials[1] = 16'hFFC0;
        specials[2] = 16'h7F81; specials[3] = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            ops = '0;
            ops[16*i +: 16] = specials[i];
            do_op(4'(1 << i), ops, 4, 16'h0000, 0, g);
        end

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            ops = '0;
            for (int k = 0; k < N; k++) begin
                op1 = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: op1[14:7] = 8'h00;
                    1: op1[14:7] = 8'hFF;
                    default: ;
                endcase
                ops[16*k +: 16] = op1;
            end
            do_op(4'($urandom_range(1, 15)), ops, int'($urandom_range(1, 70)),
                  16'($urandom), int'($urandom_range(0, 3)), g);
        end

        // Reset while waiting on the unit, then a stray unit valid in IDLE.
        req_valid = 4'hF;
        req_op    = {$urandom, $urandom};
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("reset_mid_op", obs_all(), 64'd0);
        rst = 1'b0;
        rr_m = 0;
        req_valid = '0;
        u_valid = 1'b1;
        tick();
        u_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("no_stray_rsp", 64'({rsp_valid, busy, sq_do}), 64'd0);
        end
        do_op(4'hF, {$urandom, $urandom}, 2, 16'h5555, 0, g);
        check_val("rr_after_reset", 64'(g), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
